data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 15 +
 rtl/data_mem_responder_lane_align.sv | 39 +++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared state encodings, func3 codes and widths for the data memory responder.
package data_mem_responder_pkg;
  localparam int DataWidth = 32;
  localparam int AddrWidth = 32;
  typedef enum logic [1:0] {
    MR_IDLE   = 2'd0,
    MR_ACCESS = 2'd1,
    MR_RESP   = 2'd2
  } mr_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/data_mem_responder_lane_align.sv
// mem_lane_align: byte-lane steering for stores and extension of loads, plus misalign/illegal detection.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic                 we,
  input  logic [2:0]           func3,
  input  logic [1:0]           off,
  input  logic [DataWidth-1:0] wdata,
  input  logic [DataWidth-1:0] rword,
  output logic [3:0]           be,
  output logic [DataWidth-1:0] wdata_sh,
  output logic [DataWidth-1:0] rdata,
  output logic                 err
);
  logic [DataWidth-1:0] sh;
  logic mis;
  logic ill;
  always_comb begin
    sh = rword >> {off, 3'b000};
    mis = (func3[1:0] == 2'b01 && off[0]) || (func3[1:0] == 2'b10 && off != 2'b00);
    ill = we ? !(func3 == F3_B || func3 == F3_H || func3 == F3_W)
             : (func3 == 3'b011 || func3[2:1] == 2'b11);
    err = mis || ill;
    be = err ? 4'b0000
       : func3[1:0] == 2'b00 ? 4'b0001 << off
       : func3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011)
       : 4'b1111;
    // Replicate narrow data across the word so the byte enables pick the right lanes.
    wdata_sh = func3[1:0] == 2'b00 ? {4{wdata[7:0]}}
             : func3[1:0] == 2'b01 ? {2{wdata[15:0]}}
             : wdata;
    rdata = (err || we)     ? '0
          : func3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}
          : func3 == F3_H  ? {{16{sh[15]}}, sh[15:0]}
          : func3 == F3_BU ? {24'b0, sh[7:0]}
          : func3 == F3_HU ? {16'b0, sh[15:0]}
          : sh;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder over a word array with byte-lane stores.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_func3,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  input  logic [AddrWidth-1:0] memWatchAddr,
  output logic [DataWidth-1:0] memWatchData
);
  localparam int IW = $clog2(DEPTH);
  mr_state_e state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic we_q, we_d;
  logic [2:0] func3_q, func3_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rsp_err_q, rsp_err_d;
  logic [DataWidth-1:0] mem_q [DEPTH];
  logic [IW-1:0] idx;
  logic last;
  logic wr_en;
  logic [3:0] la_be;
  logic [DataWidth-1:0] la_wdata, la_rdata;
  logic la_err;
  logic unused_bits;
  assign idx = addr_q[IW+1:2];
  assign last = wait_q == 3'(LAT);
  assign wr_en = state_q == MR_ACCESS && last && we_q && !la_err;
  assign req_ready = state_q == MR_IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign memWatchData = mem_q[memWatchAddr[IW+1:2]];
  assign unused_bits = ^{addr_q[AddrWidth-1:IW+2], memWatchAddr[AddrWidth-1:IW+2], memWatchAddr[1:0]};
  mem_lane_align u_align (
    .we       (we_q),
    .func3    (func3_q),
    .off      (addr_q[1:0]),
    .wdata    (wdata_q),
    .rword    (mem_q[idx]),
    .be       (la_be),
    .wdata_sh (la_wdata),
    .rdata    (la_rdata),
    .err      (la_err)
  );
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    we_d = we_q;
    func3_d = func3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      MR_IDLE: if (req_valid) begin
        state_d = MR_ACCESS;
        wait_d = '0;
        we_d = req_we;
        func3_d = req_func3;
        addr_d = req_addr;
        wdata_d = req_wdata;
      end
      MR_ACCESS: begin
        wait_d = last ? 3'd0 : wait_q + 3'd1;
        if (last) begin
          state_d = MR_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = la_rdata;
          rsp_err_d = la_err;
        end
      end
      MR_RESP: if (rsp_ready) begin
        state_d = MR_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = MR_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MR_IDLE;
      wait_q <= '0;
      we_q <= 1'b0;
      func3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      we_q <= we_d;
      func3_q <= func3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  // The array has no reset; an aborted access never reaches the last ACCESS edge, so it never writes.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (la_be[i]) mem_q[idx][8*i+:8] <= la_wdata[8*i+:8];
  end
endmodule
